// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: multi-channel SPI ADC sequencer with pipelined per-channel config and a one-entry result buffer
module adc_scan_ctrl #(
  parameter int DATA_W = 12,
  parameter int CFG_W = 6,
  parameter int N_CH = 8,
  parameter int SCK_DIV = 25,
  parameter int CONV_CYCLES = 80,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [N_CH*CFG_W-1:0] cfg_in,
  output logic                  convst,
  output logic                  sck,
  output logic                  sdi,
  input  logic                  sdo,
  output logic [DATA_W-1:0]     result_data,
  output logic [CH_W-1:0]       result_ch,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  overrun
);
  localparam int NB = (DATA_W > CFG_W) ? DATA_W : CFG_W;
  localparam int BW = $clog2(NB + 1);
  localparam int DW = $clog2(SCK_DIV + 1);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic [BW-1:0] bitc;
  logic [NB-1:0] tx, cfg_w;
  logic [DATA_W-1:0] rx;
  logic [N_CH-1:0] mask;
  logic cont, stop_l, prime;
  logic [CH_W-1:0] ptr, prev, first, sel;
  logic [N_CH*CFG_W-1:0] cfg_sh;
  // first enabled channel strictly after p, wrapping; p itself is reached last
  function automatic logic [CH_W-1:0] nxt(input logic [CH_W-1:0] p, input logic [N_CH-1:0] m);
    logic [N_CH-1:0] r;
    nxt = p;
    for (int i = N_CH; i >= 1; i--) begin
      r = m >> ((int'(p) + i) % N_CH);
      if (r[0]) nxt = CH_W'((int'(p) + i) % N_CH);
    end
  endfunction
  always_comb begin
    sel = (state == IDLE) ? nxt(CH_W'(N_CH - 1), ch_mask) : nxt(ptr, mask);
    cfg_sh = cfg_in >> (int'(sel) * CFG_W);
    cfg_w = NB'(cfg_sh[CFG_W-1:0]);
  end
  assign convst = state == CONV;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      div <= '0;
      bitc <= '0;
      tx <= '0;
      rx <= '0;
      mask <= '0;
      cont <= 1'b0;
      stop_l <= 1'b0;
      prime <= 1'b0;
      ptr <= '0;
      prev <= '0;
      first <= '0;
      sck <= 1'b0;
      sdi <= 1'b0;
      result_data <= '0;
      result_ch <= '0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (result_valid && result_ready) result_valid <= 1'b0;
      if (stop && state != IDLE) stop_l <= 1'b1;
      case (state)
        IDLE: if (start && |ch_mask) begin
          state <= CONV;
          mask <= ch_mask;
          cont <= continuous;
          stop_l <= 1'b0;
          prime <= 1'b1;
          overrun <= 1'b0;
          ptr <= sel;
          first <= sel;
          cnt <= '0;
          tx <= cfg_w;
        end
        CONV: if (cnt == CW'(CONV_CYCLES - 1)) begin
          state <= SHIFT;
          cnt <= '0;
          div <= '0;
          bitc <= '0;
          sdi <= tx[0];
          tx <= tx >> 1;
        end else cnt <= cnt + 1'b1;
        SHIFT: if (div == DW'(SCK_DIV - 1)) begin
          div <= '0;
          sck <= ~sck;
          if (!sck) begin
            if (bitc < BW'(DATA_W)) rx <= {sdo, rx[DATA_W-1:1]};
          end else begin
            bitc <= bitc + 1'b1;
            sdi <= tx[0];
            tx <= tx >> 1;
            if (bitc == BW'(NB - 1)) state <= DONE;
          end
        end else div <= div + 1'b1;
        DONE: begin
          if (!prime) begin
            result_valid <= 1'b1;
            result_data <= rx;
            result_ch <= prev;
            if (result_valid && !result_ready) overrun <= 1'b1;
          end
          prime <= 1'b0;
          prev <= ptr;
          ptr <= sel;
          tx <= cfg_w;
          cnt <= '0;
          state <= (!prime && (stop_l || (!cont && ptr == first))) ? IDLE : CONV;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: scoreboard bench with behavioural LTC2308-style ADC models for a 12-bit and a 16-bit instance
module tb_adc_scan_ctrl;
  localparam int F = 53;
  localparam int F16 = 69;
  typedef struct {logic [2:0] ch; logic [15:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, continuous = 1'b0, result_ready = 1'b1;
  logic [7:0] ch_mask = '0;
  logic [47:0] cfg_in = '0;
  logic convst, sck, sdi, sdo = 1'b0, result_valid, busy, overrun;
  logic [11:0] result_data;
  logic [2:0] result_ch;
  logic start16 = 1'b0, ready16 = 1'b1;
  logic [7:0] mask16 = '0;
  logic [63:0] cfg16 = '0;
  logic convst16, sck16, sdi16, sdo16 = 1'b0, rv16, busy16, ov16;
  logic [15:0] rd16;
  logic [2:0] rch16;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  exp_t sb[$];
  exp_t sb16[$];
  logic [11:0] res_tb [8];
  logic [5:0] cfg_tb [8];
  logic [5:0] cfg_log[$];
  logic [11:0] adc_val = '0, cap = '0;
  int sidx = 0, cidx = 0, n_conv = 0, n_sck = 0;
  logic [15:0] pat16 = 16'hBEEF, cap16 = '0, cap16_last = '0;
  int idx16 = 0, cidx16 = 0, n_sck16 = 0;
  logic overlap = 1'b0;

  adc_scan_ctrl #(.DATA_W(12), .CFG_W(6), .N_CH(8), .SCK_DIV(2), .CONV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous), .ch_mask(ch_mask),
    .cfg_in(cfg_in), .convst(convst), .sck(sck), .sdi(sdi), .sdo(sdo), .result_data(result_data),
    .result_ch(result_ch), .result_valid(result_valid), .result_ready(result_ready), .busy(busy),
    .overrun(overrun));

  adc_scan_ctrl #(.DATA_W(16), .CFG_W(8), .N_CH(8), .SCK_DIV(2), .CONV_CYCLES(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .stop(1'b0), .continuous(1'b0), .ch_mask(mask16),
    .cfg_in(cfg16), .convst(convst16), .sck(sck16), .sdi(sdi16), .sdo(sdo16), .result_data(rd16),
    .result_ch(rch16), .result_valid(rv16), .result_ready(ready16), .busy(busy16), .overrun(ov16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (convst && sck) overlap <= 1'b1;

  // ADC converts with the config captured during the previous frame
  always @(posedge convst) begin
    n_conv++;
    adc_val = 12'hFFF;
    for (int c = 0; c < 8; c++) if (cfg_tb[c] == cap[5:0]) adc_val = res_tb[c];
    sidx = 0;
    cidx = 0;
    cap = '0;
    sdo = adc_val[0];
  end
  always @(negedge sck) begin
    sidx++;
    sdo = (sidx < 12) ? adc_val[sidx] : 1'b0;
  end
  always @(posedge sck) begin
    if (cidx < 12) cap[cidx] = sdi;
    cidx++;
    n_sck++;
    if (cidx == 12) cfg_log.push_back(cap[5:0]);
  end
  always @(posedge convst16) begin
    idx16 = 0;
    cidx16 = 0;
    cap16 = '0;
    sdo16 = pat16[0];
  end
  always @(negedge sck16) begin
    idx16++;
    sdo16 = (idx16 < 16) ? pat16[idx16] : 1'b0;
  end
  always @(posedge sck16) begin
    if (cidx16 < 16) cap16[cidx16] = sdi16;
    cidx16++;
    n_sck16++;
    if (cidx16 == 16) cap16_last = cap16;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] m, input logic c, output int t0);
    ch_mask = m;
    continuous = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic get_result(input int budget, output bit got, output logic [11:0] d, output logic [2:0] ch, output int t);
    got = 1'b0;
    d = '0;
    ch = '0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        d = result_data;
        ch = result_ch;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    int t0, ns, nc;
    repeat (3) tick();
    n_cmp++;
    if ({convst, sck, sdi, busy, result_valid, overrun, result_data, result_ch} !== 21'h0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", {convst, sck, sdi, busy, result_valid, overrun, result_data, result_ch});
    end
    rst = 1'b1;
    tick();
    do_start(8'hFF, 1'b1, t0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = sck;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL reset_reach_shift: sck got 0 want 1");
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({convst, sck, sdi, busy, result_valid, overrun, result_data, result_ch} !== 21'h0) begin
      n_bad++;
      $display("FAIL reset_abort: got %h want 0", {convst, sck, sdi, busy, result_valid, overrun, result_data, result_ch});
    end
    tick();
    tick();
    rst = 1'b1;
    ns = n_sck;
    nc = n_conv;
    repeat (100) tick();
    n_cmp++;
    if (n_sck !== ns || n_conv !== nc || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_quiet: sck edges %0d conv %0d busy %b want 0 0 0", n_sck - ns, n_conv - nc, busy);
    end
  endtask

  task automatic test_single();
    logic [5:0] want_cfg [3];
    exp_t e;
    bit got;
    logic [11:0] d;
    logic [2:0] ch;
    int t0, t, l0, s0;
    want_cfg[0] = 6'h21;
    want_cfg[1] = 6'h2A;
    want_cfg[2] = 6'h21;
    sb.push_back('{3'd0, 16'(res_tb[0])});
    sb.push_back('{3'd2, 16'(res_tb[2])});
    l0 = cfg_log.size();
    s0 = n_sck;
    do_start(8'h05, 1'b0, t0);
    for (int i = 0; i < 2; i++) begin
      get_result(2 * F + 10, got, d, ch, t);
      e = sb.pop_front();
      n_cmp++;
      if (!got || d !== e.d[11:0] || ch !== e.ch) begin
        n_bad++;
        $display("FAIL single_result%0d: got %b ch%0d %h want ch%0d %h", i, got, ch, d, e.ch, e.d[11:0]);
      end
      n_cmp++;
      if (t - t0 !== (i + 2) * F) begin
        n_bad++;
        $display("FAIL single_latency%0d: got %0d want %0d", i, t - t0, (i + 2) * F);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy_end: got %b want 0", busy);
    end
    n_cmp++;
    if (cfg_log.size() - l0 !== 3 || n_sck - s0 !== 36) begin
      n_bad++;
      $display("FAIL single_frames: cfg frames %0d sck edges %0d want 3 36", cfg_log.size() - l0, n_sck - s0);
    end else
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (cfg_log[l0 + i] !== want_cfg[i]) begin
          n_bad++;
          $display("FAIL single_sdi%0d: got %h want %h", i, cfg_log[l0 + i], want_cfg[i]);
        end
      end
  endtask

  task automatic test_continuous();
    exp_t e;
    bit got;
    logic [11:0] d;
    logic [2:0] ch;
    int t0, t, nc;
    for (int k = 0; k < 10; k++) sb.push_back('{3'(k % 8), 16'(res_tb[k % 8])});
    nc = n_conv;
    do_start(8'hFF, 1'b1, t0);
    for (int i = 0; i < 10; i++) begin
      get_result(2 * F + 10, got, d, ch, t);
      e = sb.pop_front();
      n_cmp++;
      if (!got || d !== e.d[11:0] || ch !== e.ch) begin
        n_bad++;
        $display("FAIL cont_result%0d: got %b ch%0d %h want ch%0d %h", i, got, ch, d, e.ch, e.d[11:0]);
      end
      if (i == 8) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_stop_busy: got %b want 0", busy);
    end
    repeat (2 * F) tick();
    n_cmp++;
    if (n_conv - nc !== 11 || result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_stop_frames: convst %0d valid %b want 11 0", n_conv - nc, result_valid);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    bit ok, got;
    logic [11:0] d;
    logic [2:0] ch;
    int t0, t;
    result_ready = 1'b0;
    sb.push_back('{3'd2, 16'(res_tb[2])});
    do_start(8'h06, 1'b0, t0);
    wait_idle(4 * F, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || overrun !== 1'b1 || result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_flag: idle %b overrun %b valid %b want 1 1 1", ok, overrun, result_valid);
    end
    n_cmp++;
    if (result_data !== e.d[11:0] || result_ch !== e.ch) begin
      n_bad++;
      $display("FAIL overrun_data: got ch%0d %h want ch%0d %h", result_ch, result_data, e.ch, e.d[11:0]);
    end
    result_ready = 1'b1;
    sb.push_back('{3'd0, 16'(res_tb[0])});
    do_start(8'h01, 1'b0, t0);
    n_cmp++;
    if (overrun !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_clear: overrun %b valid %b busy %b want 0 0 1", overrun, result_valid, busy);
    end
    get_result(2 * F + 10, got, d, ch, t);
    e = sb.pop_front();
    n_cmp++;
    if (!got || d !== e.d[11:0] || ch !== e.ch || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_after: got %b ch%0d %h ov %b want ch%0d %h ov 0", got, ch, d, overrun, e.ch, e.d[11:0]);
    end
    wait_idle(2 * F, ok);
  endtask

  task automatic test_ignored_start();
    exp_t e;
    bit ok, got;
    logic [11:0] d;
    logic [2:0] ch;
    int t0, t, nc;
    nc = n_conv;
    do_start(8'h00, 1'b0, t0);
    repeat (20) tick();
    n_cmp++;
    if (busy !== 1'b0 || n_conv !== nc) begin
      n_bad++;
      $display("FAIL zero_mask: busy %b convst %0d want 0 0", busy, n_conv - nc);
    end
    sb.push_back('{3'd4, 16'(res_tb[4])});
    do_start(8'h10, 1'b0, t0);
    repeat (20) tick();
    ch_mask = 8'hFF;
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    get_result(2 * F + 10, got, d, ch, t);
    e = sb.pop_front();
    n_cmp++;
    if (!got || d !== e.d[11:0] || ch !== e.ch || t - t0 !== 2 * F) begin
      n_bad++;
      $display("FAIL busy_start: got %b ch%0d %h at %0d want ch%0d %h at %0d", got, ch, d, t - t0, e.ch, e.d[11:0], 2 * F);
    end
    wait_idle(2 * F, ok);
    n_cmp++;
    if (!ok || n_conv - nc !== 2) begin
      n_bad++;
      $display("FAIL busy_start_frames: idle %b convst %0d want 1 2", ok, n_conv - nc);
    end
  endtask

  task automatic test_wide();
    exp_t e;
    bit got;
    int t0, t, s0;
    sb16.push_back('{3'd7, 16'hBEEF});
    s0 = n_sck16;
    mask16 = 8'h80;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    t0 = cyc;
    got = 1'b0;
    t = 0;
    for (int i = 0; i < 2 * F16 + 10 && !got; i++) begin
      @(negedge clk);
      got = rv16;
      t = cyc;
    end
    e = sb16.pop_front();
    n_cmp++;
    if (!got || rd16 !== e.d || rch16 !== e.ch || t - t0 !== 2 * F16) begin
      n_bad++;
      $display("FAIL wide_result: got %b ch%0d %h at %0d want ch%0d %h at %0d", got, rch16, rd16, t - t0, e.ch, e.d, 2 * F16);
    end
    n_cmp++;
    if (n_sck16 - s0 !== 32 || cap16_last !== 16'h00C3 || busy16 !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_frames: sck %0d sdi %h busy %b want 32 00c3 0", n_sck16 - s0, cap16_last, busy16);
    end
  endtask

  initial begin
    res_tb = '{12'hA5C, 12'h111, 12'h3F0, 12'h222, 12'h4B7, 12'h5C8, 12'h6D9, 12'h7EA};
    cfg_tb = '{6'h21, 6'h01, 6'h2A, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07};
    for (int c = 0; c < 8; c++) cfg_in[c*6 +: 6] = cfg_tb[c];
    cfg16[63:56] = 8'hC3;
    @(negedge clk);
    test_reset();
    test_single();
    test_continuous();
    test_overrun();
    test_ignored_start();
    test_wide();
    n_cmp++;
    if (overlap !== 1'b0) begin
      n_bad++;
      $display("FAIL convst_sck_overlap: got %b want 0", overlap);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Parametrised multi-channel SPI ADC sequencer that drives CONVST/SCK/SDI and captures SDO for an LTC2308-class converter. It scans a programmable channel mask in single-sweep or continuous mode and loads a per-channel config word into the ADC every frame. It delivers channel-tagged results through a one-entry valid/ready buffer with overrun flagging. It sits between the system clock domain and the ADC pins, replacing the fixed single-channel controller.

## Interface
- DATA_W, 12, conversion result width
- CFG_W, 6, config word width shifted into the ADC
- N_CH, 8, number of channels; CH_W = max(1, $clog2(N_CH))
- SCK_DIV, 25, clk cycles per SCK half-period (≥1)
- CONV_CYCLES, 80, clk cycles CONVST is held high (≥1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a scan
- stop  in  1  one-cycle request to end continuous scan
- continuous  in  1  1 = repeat sweeps until stop, 0 = one sweep; sampled at start
- ch_mask  in  N_CH  enabled channels; sampled at start
- cfg_in  in  N_CH*CFG_W  per-channel config; channel c = cfg_in[c*CFG_W +: CFG_W]; read when each frame begins
- convst  out  1  ADC conversion start
- sck  out  1  serial clock, idle low
- sdi  out  1  config bits to ADC
- sdo  in  1  result bits from ADC
- result_data  out  DATA_W  captured result
- result_ch  out  CH_W  channel of result_data
- result_valid  out  1  buffer holds an unconsumed result
- result_ready  in  1  consumer accepts when valid & ready
- busy  out  1  scan in progress
- overrun  out  1  sticky: a result overwrote an unconsumed one

## Operation
- NB = max(DATA_W, CFG_W) bits per frame. All serial data LSB-first. sdi drives 0 for bit indices ≥ CFG_W. sdo bits with index ≥ DATA_W are ignored.
- States: IDLE, CONV, SHIFT, DONE.
- IDLE: start with ch_mask≠0 latches mask and mode, clears overrun, sets busy, and enters CONV. start with ch_mask=0 is ignored. start while busy is ignored.
- CONV: convst=1 for CONV_CYCLES cycles, then SHIFT.
- SHIFT: NB SCK periods. Each bit: sck low SCK_DIV cycles, then high SCK_DIV cycles. sdi is updated on the cycle sck goes low (bit 0 is set up on SHIFT entry). sdo is sampled on the clk edge that drives sck high.
- DONE: 1 cycle. Pushes result (if not the priming frame), advances the channel pointer, then CONV (next frame) or IDLE.
- Pipelining:
  - The config shifted in frame k selects the conversion of frame k+1.
  - Frame 0 after start is priming: its sdo data is discarded.
  - The result of frame k is tagged with the channel configured in frame k−1.
- Channel order: enabled channels ascending, wrapping from highest to lowest.
- Single sweep with K enabled channels runs K+1 frames. The final frame shifts cfg of the first enabled channel.
- Continuous: priming occurs once per start only. stop (latched at any time while busy) lets the current frame finish and deliver its result, then enters IDLE. The pending config is abandoned.
- Output buffer:
  - Push sets result_valid and loads data/ch.
  - valid & ready clears result_valid.
  - A push while result_valid=1 and ready=0 overwrites the data and sets overrun.
  - A push in the same cycle as a pop is a normal load with no overrun.
- busy falls in the cycle IDLE is entered.

## Timing
- Reset values: convst 0, sck 0, sdi 0, busy 0, result_valid 0, result_data 0, result_ch 0, overrun 0. Internal state is IDLE.
- rst=0 mid-frame aborts immediately. Outputs take reset values at the next edge. Any partial result is lost.
- Frame length F = CONV_CYCLES + 2·SCK_DIV·NB + 1 cycles.
- The start-accepting cycle is frame cycle 0.
- First result_valid rises 2F cycles after the start edge. Subsequent results follow every F cycles.
- Exactly NB rising sck edges per frame. convst and sck are never high together.
- Counter widths: the bit counter is sized for NB, and the divider and conv counters for their parameters. No wrap inside a frame.

## Test plan
1. Reset mid-SHIFT (rst=0 for 3 cycles) → next edge: all outputs 0, no further sck edges; a following start behaves normally.
2. Defaults with SCK_DIV=2, CONV_CYCLES=4 (F=53); single sweep, ch_mask=8'h05, cfg ch0=6'h21, ch2=6'h2A; ADC model returns 12'hA5C and 12'h3F0 → sdi frames carry 21,2A,21 LSB-first; results (0,A5C) at cycle 106 and (2,3F0) at cycle 159; busy=0 after 3 frames.
3. Continuous, ch_mask=8'hFF, result_ready=1 → result_ch sequence 0..7,0,1…; stop during frame 10 → that frame's result is delivered, then IDLE, with no extra convst.
4. result_ready=0 across two pushes → overrun=1 and held data equals the second result; a new start clears overrun.
5. start with ch_mask=0 → busy stays 0, no convst. start while busy → ignored, sequence unchanged.
6. DATA_W=16, CFG_W=8, ch_mask=8'h80 → 16 sck edges per frame; sdi bits 8–15 are 0; result_ch=7 with 16-bit data intact.
